dmem_port: RTL and testbench
============================

# dmem_port

Parametrised, multi-cycle data-memory port that sits between the rv32 core's load/store path and a word-organised data array. It accepts one request at a time over a valid/ready handshake, completes it after a configurable latency, and handles sub-word width and sign extension. It also raises an error for illegal accesses and drives the core stall (`pause`) while a request is outstanding.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1<<20: number of 32-bit words in the array. Must be a power of two.
- `LATENCY`, default 2: cycles from request acceptance to response. Legal range 1..8.

Ports:
- `clk`  input  1  clock. All state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  port can accept a request.
- `req_we`  input  1  1 = store, 0 = load.
- `req_addr`  input  32  byte address.
- `req_width`  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- `req_usignext`  input  1  1 = zero-extend loads, 0 = sign-extend loads.
- `req_wdata`  input  32  store data, right-aligned.
- `rsp_valid`  output  1  one-cycle response pulse, asserted for loads and stores.
- `rsp_rdata`  output  32  load result. 0 for stores and errors.
- `rsp_err`  output  1  access rejected. Valid only with `rsp_valid`.
- `pause`  output  1  stall to core. High while a request is outstanding.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, capture the request, load the counter with LATENCY-1 and go to WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: decrement the counter. At 0, go to RESP.
  - RESP: perform the access, assert `rsp_valid` for exactly one cycle, return to IDLE.
- Only one request is ever outstanding. `req_valid` outside IDLE is ignored; the requester holds its request until `req_ready`.
- Array index is `addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are discarded, so addresses wrap modulo the array size.
- Byte lane is selected by `addr[1:0]`. Half lane is selected by `addr[1]`.
- Loads: shift the selected lane to bit 0, then sign-extend from its top bit (unless `req_usignext`=1, which zero-extends).
- Stores: replicate the low byte/half of `req_wdata` across lanes and write only the enabled bytes. Other bytes are preserved.
- Width 11: `rsp_err`=1, no write, `rsp_rdata`=0.
- No response backpressure exists. The consumer must take `rsp_valid` in that cycle.

## Timing
- Request accepted at edge N. `rsp_valid`, `rsp_rdata` and `rsp_err` are registered and high during the cycle after edge N+LATENCY-1. That is, the response is visible LATENCY cycles after acceptance.
- A store commits at the same edge that raises `rsp_valid`. A load issued afterwards observes it.
- `pause` = (state != IDLE). A new request can be accepted in the cycle after the response, so the sustained rate is 1 per LATENCY+1 cycles.
- Reset values: state IDLE, counter 0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `pause`=0, `req_ready`=1 once reset deasserts. Array contents are not reset.
- Reset asserted mid-operation drops the pending request. No write is committed and no response is produced.

## Configuration
Macro `DMEM_MISALIGN_CHECK_EN`:
- Defined: a half access with `addr[0]`=1, or a word access with `addr[1:0]`!=0, returns `rsp_err`=1 with no write and `rsp_rdata`=0. Response latency is unchanged.
- Undefined: misaligned accesses are silently aligned down. Half ignores `addr[0]`; word ignores `addr[1:0]`. Only width 11 errors.

## Structure
- Package `dmem_pkg`: width encodings `W_BYTE`/`W_HALF`/`W_WORD`/`W_RSVD`, FSM state enum, and the `LATENCY` legal-range constants.
- Sub-module `dmem_lane_fmt` (combinational) is natural: it produces the store byte enables and replicated data, and the load lane select and extension.
- The FSM, counter, request capture registers and array stay in `dmem_port`.

## Test plan
All scenarios use LATENCY=2.
1. Store word 0xDEADBEEF @0x100, then load word @0x100 → `rsp_valid` exactly 2 cycles after each accept, `rdata`=0xDEADBEEF, `err`=0, `pause` high between accept and response.
2. Loads from the scenario-1 data:
   - byte @0x101 signed → 0xFFFFFFBE
   - byte @0x101 unsigned → 0x000000BE
   - half @0x102 signed → 0xFFFFDEAD
3. Store byte 0x55 @0x103, then load word @0x100 → 0x55ADBEEF. Store half 0x1234 @0x100, then load word → 0x55AD1234.
4. Width 11 store @0x100 → `err`=1, `rdata`=0, and a later word load still returns 0x55AD1234.
5. Misaligned word load @0x101:
   - with `DMEM_MISALIGN_CHECK_EN` → `err`=1, `rdata`=0
   - without → `err`=0, returns the word at 0x100
6. Store word 0xCAFEF00D @0x200, with reset pulsed low during WAIT → no `rsp_valid`, `req_ready`=1 after release, and a word load @0x200 returns the prior contents. Additionally, `req_valid` held high through WAIT is accepted exactly once.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the rv32 data-memory port: access widths, FSM states and
// the supported response-latency range.
package dmem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_RSVD = 2'b11;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;
    localparam int CNT_W   = $clog2(LAT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for dmem_port: store byte enables and replicated data, load
// lane extraction with sign/zero extension. Honours `DMEM_MISALIGN_CHECK_EN.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic        usignext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata,
    output logic        err
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    // Misaligned half/word accesses are aligned down by forcing the low lane bits to 0.
    always_comb begin
        lane = addr_lo;
        case (width)
            W_HALF:  lane = {addr_lo[1], 1'b0};
            W_WORD:  lane = 2'b00;
            default: lane = addr_lo;
        endcase
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        err = 1'b0;
        case (width)
            W_HALF:  err = addr_lo[0];
            W_WORD:  err = |addr_lo;
            W_RSVD:  err = 1'b1;
            default: err = 1'b0;
        endcase
    end
`else
    assign err = (width == W_RSVD);
`endif

    assign shifted = rword >> {lane, 3'b000};

    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata     = 32'h0;
        if (!err) begin
            case (width)
                W_BYTE: begin
                    be        = 4'b0001 << lane;
                    wdata_rep = {4{wdata[7:0]}};
                    rdata     = {{24{~usignext & shifted[7]}}, shifted[7:0]};
                end
                W_HALF: begin
                    be        = lane[1] ? 4'b1100 : 4'b0011;
                    wdata_rep = {2{wdata[15:0]}};
                    rdata     = {{16{~usignext & shifted[15]}}, shifted[15:0]};
                end
                W_WORD: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                    rdata     = shifted;
                end
                default: begin
                    be = 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_port.sv
// Multi-cycle data-memory port: one outstanding request, fixed LATENCY response,
// sub-word access via dmem_lane_fmt. Optional misalignment errors: `DMEM_MISALIGN_CHECK_EN.
module dmem_port
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1 << 20,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_usignext,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        pause
);

    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int LAT_EFF = (LATENCY < LAT_MIN) ? LAT_MIN :
                             (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [AW+1:0]     addr_q, addr_d;
    logic [1:0]        width_q, width_d;
    logic              usx_q, usx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              capture, access;
    logic              a_we, a_usx;
    logic [AW+1:0]     a_addr;
    logic [1:0]        a_width;
    logic [31:0]       a_wdata;
    logic [AW-1:0]     a_idx;
    logic [31:0]       rword, wdata_rep, rdata_fmt;
    logic [3:0]        be;
    logic              err;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:AW+2];

    // With LATENCY=1 the access happens on the accepting edge, so the live request
    // is used while idle; otherwise the captured copy is used.
    assign a_we    = (state_q == ST_IDLE) ? req_we           : we_q;
    assign a_addr  = (state_q == ST_IDLE) ? req_addr[AW+1:0] : addr_q;
    assign a_width = (state_q == ST_IDLE) ? req_width        : width_q;
    assign a_usx   = (state_q == ST_IDLE) ? req_usignext     : usx_q;
    assign a_wdata = (state_q == ST_IDLE) ? req_wdata        : wdata_q;
    assign a_idx   = a_addr[AW+1:2];

    dmem_lane_fmt u_fmt (
        .width     (a_width),
        .addr_lo   (a_addr[1:0]),
        .usignext  (a_usx),
        .wdata     (a_wdata),
        .rword     (rword),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata     (rdata_fmt),
        .err       (err)
    );

    // One byte-wide array per lane so each maps onto a plain write-enabled RAM.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_b [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (access && a_we && be[gi] && reset) begin
                mem_b[a_idx] <= wdata_rep[gi*8 +: 8];
            end
        end

        assign rword[gi*8 +: 8] = mem_b[a_idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (LAT_EFF == 1) begin
                        access  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        we_d    = capture ? req_we           : we_q;
        addr_d  = capture ? req_addr[AW+1:0] : addr_q;
        width_d = capture ? req_width        : width_q;
        usx_d   = capture ? req_usignext     : usx_q;
        wdata_d = capture ? req_wdata        : wdata_q;

        rsp_valid_d = access;
        rsp_err_d   = access & err;
        rsp_rdata_d = (access && !a_we && !err) ? rdata_fmt : 32'h0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            width_q     <= W_BYTE;
            usx_q       <= 1'b0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            width_q     <= width_d;
            usx_q       <= usx_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign pause     = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port (LATENCY=2): the driver queues expected responses,
// a monitor pops and checks them on every rsp_valid.
module tb_dmem_port;
    import dmem_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic        req_usignext;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        pause;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   pcyc   = 0;
    int   n_id   = 0;

    dmem_port #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_width    (req_width),
        .req_usignext (req_usignext),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .pause        (pause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            pcyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation and
    // arrive exactly LAT edges after its accept.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid with rdata=%h err=%b, expected no response",
                             rsp_rdata, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    $display("rsp #%0d: rdata=%h err=%b (expect %h/%b) cycle=%0d due=%0d",
                             e.id, rsp_rdata, rsp_err, e.rdata, e.err, pcyc, e.due);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    check("rsp_cycle", pcyc, e.due);
                end
            end else if (exp_q.size() > 0 && pcyc > exp_q[0].due) begin
                e = exp_q.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missing_rsp: got no response for #%0d, expected one at cycle %0d", e.id, e.due);
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] w,
                         input logic usx, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input bit hold);
        int guard;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_width    = w;
        req_usignext = usx;
        req_wdata    = wd;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=%b, expected 1 within 20 cycles", req_ready);
            req_valid = 1'b0;
        end else begin
            n_id++;
            exp_q.push_back('{rdata: er, err: ee, due: pcyc + LAT, id: n_id});
            $display("req #%0d: we=%b addr=%h width=%b usx=%b wdata=%h", n_id, we, addr, w, usx, wd);
            @(posedge clk);
            #1;
            if (!hold) req_valid = 1'b0;
            @(negedge clk);
            check("pause_wait", {31'h0, pause}, 32'h1);
            check("ready_wait", {31'h0, req_ready}, 32'h0);
            if (hold) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int guard;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_width    = W_WORD;
        req_usignext = 1'b0;
        req_wdata    = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("reset_pause", {31'h0, pause}, 32'h0);
        check("reset_ready", {31'h0, req_ready}, 32'h1);

        // Word store/load and sub-word loads
        issue(1'b1, 32'h100, W_WORD, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        issue(1'b0, 32'h100, W_WORD, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        issue(1'b0, 32'h101, W_BYTE, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0, 0);
        issue(1'b0, 32'h101, W_BYTE, 1'b1, 32'h0, 32'h000000BE, 1'b0, 0);
        issue(1'b0, 32'h102, W_HALF, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
        issue(1'b0, 32'h100, W_BYTE, 1'b0, 32'h0, 32'hFFFFFFEF, 1'b0, 0);
        issue(1'b0, 32'h100, W_HALF, 1'b1, 32'h0, 32'h0000BEEF, 1'b0, 0);

        // Partial stores keep the other bytes
        issue(1'b1, 32'h103, W_BYTE, 1'b0, 32'hAAAAAA55, 32'h0, 1'b0, 0);
        issue(1'b0, 32'h100, W_WORD, 1'b0, 32'h0, 32'h55ADBEEF, 1'b0, 0);
        issue(1'b1, 32'h100, W_HALF, 1'b0, 32'hFFFF1234, 32'h0, 1'b0, 0);
        issue(1'b0, 32'h100, W_WORD, 1'b0, 32'h0, 32'h55AD1234, 1'b0, 0);

        // Reserved width
        issue(1'b1, 32'h100, W_RSVD, 1'b0, 32'h99999999, 32'h0, 1'b1, 0);
        issue(1'b0, 32'h100, W_RSVD, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b0, 32'h100, W_WORD, 1'b0, 32'h0, 32'h55AD1234, 1'b0, 0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_CHECK_EN
        issue(1'b0, 32'h101, W_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b0, 32'h101, W_HALF, 1'b1, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b1, 32'h102, W_WORD, 1'b0, 32'h77777777, 32'h0, 1'b1, 0);
        issue(1'b0, 32'h100, W_WORD, 1'b0, 32'h0, 32'h55AD1234, 1'b0, 0);
`else
        issue(1'b0, 32'h101, W_WORD, 1'b0, 32'h0, 32'h55AD1234, 1'b0, 0);
        issue(1'b0, 32'h101, W_HALF, 1'b1, 32'h0, 32'h00001234, 1'b0, 0);
`endif

        // Address wraps modulo the array size
        issue(1'b0, 32'h100 + DEPTH * 4, W_WORD, 1'b0, 32'h0, 32'h55AD1234, 1'b0, 0);

        // Reset during WAIT drops the store
        issue(1'b1, 32'h200, W_WORD, 1'b0, 32'h11223344, 32'h0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h200;
        req_width = W_WORD;
        req_wdata = 32'hCAFEF00D;
        check("ready_before_reset_req", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pause_before_reset", {31'h0, pause}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'h0, req_ready}, 32'h1);
        check("pause_after_reset", {31'h0, pause}, 32'h0);
        check("rsp_valid_after_reset", {31'h0, rsp_valid}, 32'h0);
        issue(1'b0, 32'h200, W_WORD, 1'b0, 32'h0, 32'h11223344, 1'b0, 0);

        // Request held through WAIT is taken once
        issue(1'b0, 32'h100, W_WORD, 1'b0, 32'h0, 32'h55AD1234, 1'b0, 1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
